// File: rtl/tl_ecc_dmem_ctrl_pkg.sv
// Shared definitions for the ECC-protected TileLink-UL data-memory controller.
// Holds the TileLink opcode constants, the controller FSM state type, the
// codeword geometry and the SECDED (39,32) parity-check matrix with a helper
// that computes the 7 check bits for a 32-bit data word.
package tl_ecc_dmem_ctrl_pkg;

  localparam int DATA_W   = 32;
  localparam int CHECK_W  = 7;
  localparam int CW_WIDTH = 39;

  // Channel A opcodes
  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_GET         = 3'd4;
  // Channel D opcodes
  localparam logic [2:0] OP_ACK         = 3'd0;
  localparam logic [2:0] OP_ACK_DATA    = 3'd1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR     = 3'd1,
    RD     = 3'd2,
    CHK    = 3'd3,
    RMW_WR = 3'd4,
    RESP   = 3'd5
  } state_e;

  // Parity-check matrix columns for data bits 31..0 (listed MSB first).
  // Every data column has weight 3 and the check-bit columns are the unit
  // vectors, so any single-bit error gives an odd-weight syndrome equal to
  // one column and any double-bit error gives a non-zero even-weight one.
  localparam logic [31:0][6:0] SECDED_H = {
    7'h62, 7'h61, 7'h58, 7'h54, 7'h52, 7'h51, 7'h4C, 7'h4A,
    7'h49, 7'h46, 7'h45, 7'h43, 7'h38, 7'h34, 7'h32, 7'h31,
    7'h2C, 7'h2A, 7'h29, 7'h26, 7'h25, 7'h23, 7'h1C, 7'h1A,
    7'h19, 7'h16, 7'h15, 7'h13, 7'h0E, 7'h0D, 7'h0B, 7'h07
  };

  function automatic logic [CHECK_W-1:0] calc_check(input logic [DATA_W-1:0] data);
    logic [CHECK_W-1:0] chk;
    chk = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (data[i]) chk = chk ^ SECDED_H[i];
    end
    return chk;
  endfunction

endpackage

// File: rtl/tl_ecc_dmem_ctrl_secded.sv
// SECDED (39,32) encoder and decoder, purely combinational.
// Codeword layout is {check[6:0], data[31:0]}.
// Ports:
//   enc_data_i     data word to encode
//   enc_cw_o       encoded codeword
//   dec_cw_i       codeword read back from memory
//   dec_syndrome_o recomputed check bits XOR stored check bits
//   dec_data_o     data with a single-bit error corrected
//   dec_single_o   syndrome matches exactly one codeword bit
//   dec_double_o   non-zero syndrome that matches no single bit
module secded_39_32
  import tl_ecc_dmem_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0]   enc_data_i,
  output logic [CW_WIDTH-1:0] enc_cw_o,
  input  logic [CW_WIDTH-1:0] dec_cw_i,
  output logic [CHECK_W-1:0]  dec_syndrome_o,
  output logic [DATA_W-1:0]   dec_data_o,
  output logic                dec_single_o,
  output logic                dec_double_o
);

  always_comb begin
    enc_cw_o = {calc_check(enc_data_i), enc_data_i};
  end

  always_comb begin
    dec_syndrome_o = calc_check(dec_cw_i[DATA_W-1:0]) ^ dec_cw_i[CW_WIDTH-1:DATA_W];
    dec_data_o     = dec_cw_i[DATA_W-1:0];
    dec_single_o   = 1'b0;
    // Data-bit error: flip the matching bit back.
    for (int i = 0; i < DATA_W; i++) begin
      if (dec_syndrome_o == SECDED_H[i]) begin
        dec_data_o[i] = ~dec_cw_i[i];
        dec_single_o  = 1'b1;
      end
    end
    // Check-bit error: data is already correct, still reported as corrected.
    for (int j = 0; j < CHECK_W; j++) begin
      if (dec_syndrome_o == (7'd1 << j)) dec_single_o = 1'b1;
    end
    dec_double_o = (dec_syndrome_o != '0) && !dec_single_o;
  end

endmodule

// File: rtl/tl_ecc_dmem_ctrl.sv
// TileLink-UL slave in front of a single-port SECDED-protected data memory.
// Get reads and checks a word; PutFullData with all lanes writes directly;
// partial puts read, correct, merge and write back the whole codeword.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   a_*               TileLink channel A (request)
//   d_*               TileLink channel D (response)
//   mem_*             data-memory port, read data valid the cycle after access
//   err_corr/uncorr   one-cycle pulses for corrected / uncorrectable errors
// Handshake: a transfer on either channel happens on a rising edge where
// valid and ready are both 1; once d_valid rises, it and every d_* field hold
// until that edge, and a_ready is 1 only while the controller is idle.
module tl_ecc_dmem_ctrl
  import tl_ecc_dmem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH   = 13,
  parameter int SOURCE_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [2:0]              a_opcode,
  input  logic [1:0]              a_size,
  input  logic [SOURCE_WIDTH-1:0] a_source,
  input  logic [ADDR_WIDTH+1:0]   a_address,
  input  logic [3:0]              a_mask,
  input  logic [31:0]             a_data,
  output logic                    d_valid,
  input  logic                    d_ready,
  output logic [2:0]              d_opcode,
  output logic [1:0]              d_size,
  output logic [SOURCE_WIDTH-1:0] d_source,
  output logic                    d_denied,
  output logic                    d_corrupt,
  output logic [31:0]             d_data,
  output logic                    mem_clk_en,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_write_en,
  output logic [CW_WIDTH-1:0]     mem_write_data,
  input  logic [CW_WIDTH-1:0]     mem_read_data,
  output logic                    err_corr,
  output logic                    err_uncorr
);

  state_e                  state_q;
  logic                    a_ready_q;
  logic                    d_valid_q;
  logic [2:0]              d_opcode_q;
  logic [1:0]              d_size_q;
  logic [SOURCE_WIDTH-1:0] d_source_q;
  logic                    d_denied_q;
  logic                    d_corrupt_q;
  logic [31:0]             d_data_q;
  logic                    mem_clk_en_q;
  logic                    mem_write_en_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [31:0]             wdata_q;
  logic [3:0]              mask_q;
  logic                    is_get_q;
  logic                    err_corr_q;
  logic                    err_uncorr_q;

  logic [6:0]  dec_syndrome;
  logic [31:0] dec_data;
  logic        dec_single;
  logic        dec_double;
  logic [31:0] merge_d;

  logic req_get;
  logic req_put;
  logic req_legal;

  assign req_get   = (a_opcode == OP_GET);
  assign req_put   = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PARTIAL);
  assign req_legal = (req_get || req_put) && (a_size != 2'd3);

  // The encoder always sees the pending write word, so mem_write_data is
  // ready in WR (direct put) and in RMW_WR (merged word).
  secded_39_32 u_secded (
    .enc_data_i     (wdata_q),
    .enc_cw_o       (mem_write_data),
    .dec_cw_i       (mem_read_data),
    .dec_syndrome_o (dec_syndrome),
    .dec_data_o     (dec_data),
    .dec_single_o   (dec_single),
    .dec_double_o   (dec_double)
  );

  // Written lanes come from the request, the rest from the corrected read.
  always_comb begin
    merge_d = dec_data;
    for (int i = 0; i < 4; i++) begin
      if (mask_q[i]) merge_d[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      a_ready_q      <= 1'b1;
      d_valid_q      <= 1'b0;
      d_opcode_q     <= OP_ACK;
      d_size_q       <= '0;
      d_source_q     <= '0;
      d_denied_q     <= 1'b0;
      d_corrupt_q    <= 1'b0;
      d_data_q       <= '0;
      mem_clk_en_q   <= 1'b0;
      mem_write_en_q <= 1'b0;
      mem_addr_q     <= '0;
      wdata_q        <= '0;
      mask_q         <= '0;
      is_get_q       <= 1'b0;
      err_corr_q     <= 1'b0;
      err_uncorr_q   <= 1'b0;
    end else begin
      err_corr_q   <= 1'b0;
      err_uncorr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (a_valid) begin
            a_ready_q   <= 1'b0;
            d_size_q    <= a_size;
            d_source_q  <= a_source;
            mem_addr_q  <= a_address[ADDR_WIDTH+1:2];
            wdata_q     <= a_data;
            mask_q      <= a_mask;
            is_get_q    <= req_get;
            d_denied_q  <= 1'b0;
            d_corrupt_q <= 1'b0;
            d_opcode_q  <= req_get ? OP_ACK_DATA : OP_ACK;
            if (!req_legal) begin
              d_denied_q <= 1'b1;
              d_valid_q  <= 1'b1;
              state_q    <= RESP;
            end else if (req_get) begin
              mem_clk_en_q <= 1'b1;
              state_q      <= RD;
            end else if (a_mask == 4'h0) begin
              d_valid_q <= 1'b1;
              state_q   <= RESP;
            end else if ((a_opcode == OP_PUT_FULL) && (a_mask == 4'hF)) begin
              mem_clk_en_q   <= 1'b1;
              mem_write_en_q <= 1'b1;
              state_q        <= WR;
            end else begin
              mem_clk_en_q <= 1'b1;
              state_q      <= RD;
            end
          end
        end
        WR: begin
          mem_clk_en_q   <= 1'b0;
          mem_write_en_q <= 1'b0;
          d_valid_q      <= 1'b1;
          state_q        <= RESP;
        end
        RD: begin
          mem_clk_en_q <= 1'b0;
          state_q      <= CHK;
        end
        CHK: begin
          if (dec_double) begin
            err_uncorr_q <= 1'b1;
            if (is_get_q) begin
              d_corrupt_q <= 1'b1;
              d_data_q    <= mem_read_data[31:0];
            end else begin
              // Never write back a merge built on uncorrectable data.
              d_denied_q <= 1'b1;
            end
            d_valid_q <= 1'b1;
            state_q   <= RESP;
          end else begin
            err_corr_q <= dec_single;
            if (is_get_q) begin
              d_data_q  <= dec_data;
              d_valid_q <= 1'b1;
              state_q   <= RESP;
            end else begin
              wdata_q        <= merge_d;
              mem_clk_en_q   <= 1'b1;
              mem_write_en_q <= 1'b1;
              state_q        <= RMW_WR;
            end
          end
        end
        RMW_WR: begin
          mem_clk_en_q   <= 1'b0;
          mem_write_en_q <= 1'b0;
          d_valid_q      <= 1'b1;
          state_q        <= RESP;
        end
        RESP: begin
          if (d_ready) begin
            d_valid_q   <= 1'b0;
            d_denied_q  <= 1'b0;
            d_corrupt_q <= 1'b0;
            a_ready_q   <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          mem_clk_en_q   <= 1'b0;
          mem_write_en_q <= 1'b0;
          d_valid_q      <= 1'b0;
          a_ready_q      <= 1'b1;
          state_q        <= IDLE;
        end
      endcase
    end
  end

  assign a_ready      = a_ready_q;
  assign d_valid      = d_valid_q;
  assign d_opcode     = d_opcode_q;
  assign d_size       = d_size_q;
  assign d_source     = d_source_q;
  assign d_denied     = d_denied_q;
  assign d_corrupt    = d_corrupt_q;
  assign d_data       = d_data_q;
  assign mem_clk_en   = mem_clk_en_q;
  assign mem_addr     = mem_addr_q;
  assign mem_write_en = mem_write_en_q;
  assign err_corr     = err_corr_q;
  assign err_uncorr   = err_uncorr_q;

  // Byte offset is ignored (word-only memory); the syndrome itself is
  // summarised by the single/double flags.
  logic unused_ok;
  assign unused_ok = ^{a_address[1:0], dec_syndrome};

endmodule

// File: tb/tb_tl_ecc_dmem_ctrl.sv
// Directed bench for tl_ecc_dmem_ctrl with a behavioural codeword memory,
// a fault-injection hook and an expected-response scoreboard.
module tb_tl_ecc_dmem_ctrl;

  localparam int AW    = 13;
  localparam int SW    = 4;
  localparam int EXP_W = 48;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          a_valid, a_ready;
  logic [2:0]    a_opcode;
  logic [1:0]    a_size;
  logic [SW-1:0] a_source;
  logic [AW+1:0] a_address;
  logic [3:0]    a_mask;
  logic [31:0]   a_data;
  logic          d_valid, d_ready;
  logic [2:0]    d_opcode;
  logic [1:0]    d_size;
  logic [SW-1:0] d_source;
  logic          d_denied, d_corrupt;
  logic [31:0]   d_data;
  logic          mem_clk_en, mem_write_en;
  logic [AW-1:0] mem_addr;
  logic [38:0]   mem_write_data, mem_read_data;
  logic          err_corr, err_uncorr;

  tl_ecc_dmem_ctrl #(.ADDR_WIDTH(AW), .SOURCE_WIDTH(SW)) dut (
    .clk            (clk),
    .rst            (rst),
    .a_valid        (a_valid),
    .a_ready        (a_ready),
    .a_opcode       (a_opcode),
    .a_size         (a_size),
    .a_source       (a_source),
    .a_address      (a_address),
    .a_mask         (a_mask),
    .a_data         (a_data),
    .d_valid        (d_valid),
    .d_ready        (d_ready),
    .d_opcode       (d_opcode),
    .d_size         (d_size),
    .d_source       (d_source),
    .d_denied       (d_denied),
    .d_corrupt      (d_corrupt),
    .d_data         (d_data),
    .mem_clk_en     (mem_clk_en),
    .mem_addr       (mem_addr),
    .mem_write_en   (mem_write_en),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .err_corr       (err_corr),
    .err_uncorr     (err_uncorr)
  );

  // ---------------- memory model ----------------
  logic [38:0]   mem [0:(1<<AW)-1];
  logic [38:0]   rd_q = '0;
  logic          flip_req = 1'b0;
  logic [AW-1:0] flip_addr = '0;
  logic [38:0]   flip_msk = '0;
  assign mem_read_data = rd_q;

  always @(posedge clk) begin
    if (flip_req) mem[flip_addr] <= mem[flip_addr] ^ flip_msk;
    if (mem_clk_en && mem_write_en) mem[mem_addr] <= mem_write_data;
    if (mem_clk_en && !mem_write_en) rd_q <= mem[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [EXP_W-1:0] exp_q[$];
  int               acc_q[$];

  int            wr_cnt = 0, rd_cnt = 0, corr_cnt = 0, uncorr_cnt = 0;
  logic [AW-1:0] last_wr_addr = '0;
  logic [38:0]   last_wr_cw = '0;
  bit            dv_prev = 1'b0;
  int            first_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Packed expectation: {lat[3:0], op[2:0], denied, corrupt, chk_data, src[3:0], size[1:0], data[31:0]}
  function automatic logic [EXP_W-1:0] mk(input int lat, input logic [2:0] op, input logic den,
                                          input logic cor, input logic chk, input logic [3:0] src,
                                          input logic [1:0] sz, input logic [31:0] data);
    logic [3:0] l;
    l = lat[3:0];
    return {l, op, den, cor, chk, src, sz, data};
  endfunction

  always @(negedge clk) begin : monitor
    logic [EXP_W-1:0] e;
    int a;
    if (mem_clk_en && mem_write_en) begin
      wr_cnt++;
      last_wr_addr = mem_addr;
      last_wr_cw   = mem_write_data;
    end
    if (mem_clk_en && !mem_write_en) rd_cnt++;
    if (err_corr) corr_cnt++;
    if (err_uncorr) uncorr_cnt++;
    if (!rst) begin
      dv_prev = 1'b0;
    end else begin
      if (d_valid && !dv_prev) first_cyc = cyc;
      dv_prev = d_valid;
      if (d_valid && d_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_response: got opcode %0d with nothing expected (cycle %0d)", d_opcode, cyc);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("d_opcode",  64'(d_opcode),  64'(e[43:41]));
          check("d_denied",  64'(d_denied),  64'(e[40]));
          check("d_corrupt", 64'(d_corrupt), 64'(e[39]));
          check("d_source",  64'(d_source),  64'(e[37:34]));
          check("d_size",    64'(d_size),    64'(e[33:32]));
          if (e[38]) check("d_data", 64'(d_data), 64'(e[31:0]));
          check("latency", 64'(first_cyc - a), 64'(e[47:44]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [2:0] op, input logic [1:0] sz, input logic [3:0] src,
                      input logic [AW+1:0] addr, input logic [3:0] msk, input logic [31:0] dat,
                      input logic [EXP_W-1:0] e, input bit push);
    int k;
    @(negedge clk);
    a_opcode  = op;
    a_size    = sz;
    a_source  = src;
    a_address = addr;
    a_mask    = msk;
    a_data    = dat;
    a_valid   = 1'b1;
    k = 0;
    while (!a_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("a_ready_at_issue", 64'(a_ready), 64'd1);
    if (push) begin
      exp_q.push_back(e);
      acc_q.push_back(cyc);
    end
    @(posedge clk);
    #1 a_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!(exp_q.size() == 0 && a_ready) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("idle_reached", 64'(a_ready && exp_q.size() == 0), 64'd1);
    @(negedge clk);
  endtask

  task automatic flip(input logic [AW-1:0] addr, input logic [38:0] msk);
    @(negedge clk);
    flip_addr = addr;
    flip_msk  = msk;
    flip_req  = 1'b1;
    @(posedge clk);
    #1 flip_req = 1'b0;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin : stim
    int w0, r0, c0, u0, k;
    rst = 1'b0; a_valid = 1'b0; d_ready = 1'b1;
    a_opcode = '0; a_size = '0; a_source = '0; a_address = '0; a_mask = '0; a_data = '0;
    repeat (3) @(negedge clk);
    check("rst_d_valid",      64'(d_valid),      64'd0);
    check("rst_a_ready",      64'(a_ready),      64'd1);
    check("rst_mem_clk_en",   64'(mem_clk_en),   64'd0);
    check("rst_mem_write_en", 64'(mem_write_en), 64'd0);
    check("rst_err_corr",     64'(err_corr),     64'd0);
    check("rst_err_uncorr",   64'(err_uncorr),   64'd0);
    check("rst_d_denied",     64'(d_denied),     64'd0);
    check("rst_d_corrupt",    64'(d_corrupt),    64'd0);
    rst = 1'b1;

    // PutFull 0xDEADBEEF at byte 0x10 -> word 4
    w0 = wr_cnt; r0 = rd_cnt;
    send(3'd0, 2'd2, 4'd3, 15'h10, 4'hF, 32'hDEADBEEF, mk(2, 3'd0, 0, 0, 0, 4'd3, 2'd2, 32'h0), 1);
    wait_idle();
    check("putfull_writes",  64'(wr_cnt - w0), 64'd1);
    check("putfull_reads",   64'(rd_cnt - r0), 64'd0);
    check("putfull_addr",    64'(last_wr_addr), 64'd4);
    check("putfull_cw_data", 64'(last_wr_cw[31:0]), 64'hDEADBEEF);

    // Get it back
    w0 = wr_cnt; r0 = rd_cnt;
    send(3'd4, 2'd2, 4'd5, 15'h10, 4'hF, 32'h0, mk(3, 3'd1, 0, 0, 1, 4'd5, 2'd2, 32'hDEADBEEF), 1);
    wait_idle();
    check("get_writes", 64'(wr_cnt - w0), 64'd0);
    check("get_reads",  64'(rd_cnt - r0), 64'd1);

    // PutPartial lanes 1:0 = 0x1234
    w0 = wr_cnt; r0 = rd_cnt;
    send(3'd1, 2'd2, 4'd6, 15'h10, 4'b0011, 32'h00001234, mk(4, 3'd0, 0, 0, 0, 4'd6, 2'd2, 32'h0), 1);
    wait_idle();
    check("rmw_reads",   64'(rd_cnt - r0), 64'd1);
    check("rmw_writes",  64'(wr_cnt - w0), 64'd1);
    check("rmw_cw_data", 64'(last_wr_cw[31:0]), 64'hDEAD1234);
    send(3'd4, 2'd2, 4'd1, 15'h10, 4'hF, 32'h0, mk(3, 3'd1, 0, 0, 1, 4'd1, 2'd2, 32'hDEAD1234), 1);
    wait_idle();

    // Single-bit fault on bit 5: corrected, no write-back
    flip(13'd4, 39'h20);
    w0 = wr_cnt; c0 = corr_cnt; u0 = uncorr_cnt;
    send(3'd4, 2'd2, 4'd2, 15'h10, 4'hF, 32'h0, mk(3, 3'd1, 0, 0, 1, 4'd2, 2'd2, 32'hDEAD1234), 1);
    wait_idle();
    check("sbe_corr_pulses",   64'(corr_cnt - c0),   64'd1);
    check("sbe_uncorr_pulses", 64'(uncorr_cnt - u0), 64'd0);
    check("sbe_no_scrub",      64'(wr_cnt - w0),     64'd0);

    // Restore bit 5, flip bits 3 and 20: RMW must be refused
    flip(13'd4, 39'h100028);
    w0 = wr_cnt; c0 = corr_cnt; u0 = uncorr_cnt;
    send(3'd1, 2'd2, 4'd9, 15'h10, 4'b0001, 32'h000000FF, mk(3, 3'd0, 1, 0, 0, 4'd9, 2'd2, 32'h0), 1);
    wait_idle();
    check("dbe_uncorr_pulses", 64'(uncorr_cnt - u0), 64'd1);
    check("dbe_corr_pulses",   64'(corr_cnt - c0),   64'd0);
    check("dbe_no_rmw_write",  64'(wr_cnt - w0),     64'd0);
    // Uncorrectable Get returns raw bits flagged corrupt
    u0 = uncorr_cnt;
    send(3'd4, 2'd2, 4'd4, 15'h10, 4'hF, 32'h0, mk(3, 3'd1, 0, 1, 1, 4'd4, 2'd2, 32'hDEBD123C), 1);
    wait_idle();
    check("dbe_get_uncorr_pulses", 64'(uncorr_cnt - u0), 64'd1);

    // Back-pressure in RESP
    send(3'd0, 2'd2, 4'd7, 15'h20, 4'hF, 32'h0BADF00D, mk(2, 3'd0, 0, 0, 0, 4'd7, 2'd2, 32'h0), 1);
    wait_idle();
    d_ready = 1'b0;
    send(3'd4, 2'd2, 4'd8, 15'h20, 4'hF, 32'h0, mk(3, 3'd1, 0, 0, 1, 4'd8, 2'd2, 32'h0BADF00D), 1);
    k = 0;
    while (!d_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 5; i++) begin
      check("stall_d_valid",  64'(d_valid),  64'd1);
      check("stall_a_ready",  64'(a_ready),  64'd0);
      check("stall_d_data",   64'(d_data),   64'h0BADF00D);
      check("stall_d_source", 64'(d_source), 64'd8);
      @(negedge clk);
    end
    @(posedge clk);
    #1 d_ready = 1'b1;
    wait_idle();

    // PutFull with partial mask is a RMW: lanes 3:2 from data
    send(3'd0, 2'd2, 4'd10, 15'h20, 4'hC, 32'hAAAA5555, mk(4, 3'd0, 0, 0, 0, 4'd10, 2'd2, 32'h0), 1);
    wait_idle();
    send(3'd4, 2'd2, 4'd11, 15'h20, 4'hF, 32'h0, mk(3, 3'd1, 0, 0, 1, 4'd11, 2'd2, 32'hAAAAF00D), 1);
    wait_idle();

    // Direct responses: illegal opcode, oversize Get, empty-mask Put
    w0 = wr_cnt; r0 = rd_cnt;
    send(3'd2, 2'd2, 4'd12, 15'h20, 4'hF, 32'h0, mk(1, 3'd0, 1, 0, 0, 4'd12, 2'd2, 32'h0), 1);
    wait_idle();
    send(3'd4, 2'd3, 4'd13, 15'h20, 4'hF, 32'h0, mk(1, 3'd1, 1, 0, 0, 4'd13, 2'd3, 32'h0), 1);
    wait_idle();
    send(3'd0, 2'd2, 4'd14, 15'h20, 4'h0, 32'h12345678, mk(1, 3'd0, 0, 0, 0, 4'd14, 2'd2, 32'h0), 1);
    wait_idle();
    check("direct_no_reads",  64'(rd_cnt - r0), 64'd0);
    check("direct_no_writes", 64'(wr_cnt - w0), 64'd0);

    // Reset while in RD of a partial write: transaction abandoned
    w0 = wr_cnt;
    send(3'd1, 2'd2, 4'd15, 15'h10, 4'b0001, 32'h00000055, 48'h0, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_abort_d_valid", 64'(d_valid), 64'd0);
      check("rst_abort_a_ready", 64'(a_ready), 64'd1);
    end
    check("rst_abort_no_write", 64'(wr_cnt - w0), 64'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
